// File: rtl/mos_strength_pkg.sv
// Shared types and helpers for the complementary switch driver controller.
// Contents: channel logic-state enum, update-mode enum, controller FSM enum,
// and alt_pattern(), which builds the alternating base polarity pattern.
package mos_strength_pkg;

    // Widest channel count alt_pattern() can build; callers truncate to NCH.
    localparam int unsigned MAX_NCH = 64;

    typedef enum logic {
        St0 = 1'b0,
        St1 = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        M_HOLD   = 2'd0,
        M_TOGGLE = 2'd1,
        M_ROTATE = 2'd2,
        M_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEAD  = 2'd1,
        S_DRIVE = 2'd2
    } fsm_e;

    // a=1: even channels St0, odd channels St1; a=0 inverts. Bits >= nch are 0.
    function automatic logic [MAX_NCH-1:0] alt_pattern(input logic a, input int unsigned nch);
        logic [MAX_NCH-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_NCH; i++) begin
            if (i < nch) begin
                p[i] = (i[0] == 1'b1) ? a : ~a;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mos_pattern_next.sv
// Next channel pattern for one update step (combinational).
// Ports:
//   cur   in  NCH  current channel states
//   mode  in  2    update mode (HOLD, TOGGLE, ROTATE; reserved acts as HOLD)
//   nxt_c out NCH  pattern to apply at the next update
module mos_pattern_next
    import mos_strength_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0] cur,
    input  logic [1:0]     mode,
    output logic [NCH-1:0] nxt_c
);

    always_comb begin
        nxt_c = cur;
        case (mode_e'(mode))
            M_TOGGLE: nxt_c = ~cur;
            M_ROTATE: nxt_c = {cur[NCH-2:0], cur[NCH-1]};
            default:  nxt_c = cur;
        endcase
    end

endmodule

// File: rtl/mos_strength_array.sv
// N-channel complementary switch driver controller with break-before-make.
// Holds a per-channel St0/St1 state and drives an nmos enable (pull to 0) and
// a pmos enable (pull to 1) per channel, updating the pattern every period
// DRIVE cycles. Channels about to change are released for DEAD_CYC cycles
// before their opposite device is enabled; unchanged channels keep driving.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, stop     begin sequence (IDLE only) / abort to IDLE from anywhere
//   a, pat_i        base polarity and XOR mask, sampled at start
//   mode, period    update mode and update period, sampled at start
//   state_o         channel states (1 = St1)
//   zn_en, zp_en    nmos / pmos enables per channel
//   busy            high whenever not IDLE
module mos_strength_array
    import mos_strength_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic [NCH-1:0]   pat_i,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    output logic [NCH-1:0]   state_o,
    output logic [NCH-1:0]   zn_en,
    output logic [NCH-1:0]   zp_en,
    output logic             busy
);

    localparam int unsigned DCNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    fsm_e              fsm_q,    fsm_d;
    mode_e             mode_q,   mode_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DCNT_W-1:0] dcnt_q,   dcnt_d;
    logic [NCH-1:0]    pend_q,   pend_d;
    logic [NCH-1:0]    state_d;
    logic [NCH-1:0]    zn_d, zp_d;
    logic              busy_d;
    logic [NCH-1:0]    nxt_c;
    logic [NCH-1:0]    start_pat_c;
    logic [NCH-1:0]    chg_c;

    assign start_pat_c = NCH'(alt_pattern(a, NCH)) ^ pat_i;
    assign chg_c       = nxt_c ^ state_o;

    mos_pattern_next #(
        .NCH (NCH)
    ) u_next (
        .cur   (state_o),
        .mode  (mode_q),
        .nxt_c (nxt_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        fsm_d    = fsm_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        pend_d   = pend_q;
        state_d  = state_o;
        zn_d     = zn_en;
        zp_d     = zp_en;

        if (stop) begin
            fsm_d = S_IDLE;
            zn_d  = '0;
            zp_d  = '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    zn_d = '0;
                    zp_d = '0;
                    if (start) begin
                        mode_d   = mode_e'(mode);
                        period_d = (period == '0) ? CNT_W'(1) : period;
                        state_d  = start_pat_c;
                        pend_d   = start_pat_c;
                        dcnt_d   = DCNT_W'(DEAD_CYC - 1);
                        fsm_d    = S_DEAD;
                    end
                end
                // Enables were set on entry and simply hold through the gap.
                S_DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = pend_q;
                        zn_d    = ~pend_q;
                        zp_d    = pend_q;
                        cnt_d   = period_q - CNT_W'(1);
                        fsm_d   = S_DRIVE;
                    end else begin
                        dcnt_d = dcnt_q - DCNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    zn_d = ~state_o;
                    zp_d = state_o;
                    if (cnt_q == '0) begin
                        if (chg_c == '0) begin
                            cnt_d = period_q - CNT_W'(1);
                        end else begin
                            // Release only the channels that are about to flip.
                            pend_d = nxt_c;
                            zn_d   = ~state_o & ~chg_c;
                            zp_d   = state_o & ~chg_c;
                            dcnt_d = DCNT_W'(DEAD_CYC - 1);
                            fsm_d  = S_DEAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    fsm_d = S_IDLE;
                    zn_d  = '0;
                    zp_d  = '0;
                end
            endcase
        end

        busy_d = (fsm_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= S_IDLE;
            mode_q   <= M_HOLD;
            period_q <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            pend_q   <= '0;
            state_o  <= '0;
            zn_en    <= '0;
            zp_en    <= '0;
            busy     <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            pend_q   <= pend_d;
            state_o  <= state_d;
            zn_en    <= zn_d;
            zp_en    <= zp_d;
            busy     <= busy_d;
        end
    end

endmodule
